// File: rtl/counter_sequencer.sv
// Run/pause/load sequencer for a 4-bit counter: key sync + edge detect, prescaler, control FSM.
// Optional key debounce filter is enabled by defining CNT_SEQ_DEBOUNCE_EN.
module counter_sequencer #(
  parameter int unsigned PRESCALE        = 50000000,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_start_n,
  input  logic       key_stop_n,
  input  logic       key_load_n,
  input  logic [3:0] sw_d,
  input  logic       up,
  input  logic       wrap_en,
  output logic [3:0] count,
  output logic [1:0] state,
  output logic       tick,
  output logic       done,
  output logic       busy
);

  localparam logic [1:0] StIdle  = 2'b00;
  localparam logic [1:0] StRun   = 2'b01;
  localparam logic [1:0] StPause = 2'b10;
  localparam logic [1:0] StDone  = 2'b11;

  localparam int unsigned PreW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(PRESCALE - 1);

  // Key vector order: {load, stop, start}
  logic [2:0] w_keys_n;
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] r_prev;
  logic [2:0] w_level;
  logic [2:0] w_pulse;

  assign w_keys_n = {key_load_n, key_stop_n, key_start_n};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 3'b111;
      r_sync2 <= 3'b111;
    end else begin
      r_sync1 <= w_keys_n;
      r_sync2 <= r_sync1;
    end
  end

`ifdef CNT_SEQ_DEBOUNCE_EN
  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DbW-1:0] r_db_cnt [3];
  logic [2:0]     r_db_lvl;

  // Filtered level flips only on the DEBOUNCE_CYCLES-th consecutive differing sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_lvl <= 3'b111;
      for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_db_lvl[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DbW'(DEBOUNCE_CYCLES - 1)) begin
          r_db_lvl[i] <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DbW'(1);
        end
      end
    end
  end

  assign w_level = r_db_lvl;
`else
  localparam int unsigned unused_debounce_cycles = DEBOUNCE_CYCLES;

  assign w_level = r_sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 3'b111;
    end else begin
      r_prev <= w_level;
    end
  end

  assign w_pulse = r_prev & ~w_level;

  logic w_start;
  logic w_stop;
  logic w_load;

  assign w_start = w_pulse[0];
  assign w_stop  = w_pulse[1];
  assign w_load  = w_pulse[2];

  logic [1:0]      r_state;
  logic [3:0]      r_count;
  logic [PreW-1:0] r_pre;
  logic            r_tick;
  logic [1:0]      w_state_nxt;
  logic [3:0]      w_count_nxt;
  logic [PreW-1:0] w_pre_nxt;
  logic            w_tick_nxt;
  logic            w_roll;
  logic            w_term;

  assign w_roll = (r_pre == PreMax);
  assign w_term = up ? (r_count == 4'hF) : (r_count == 4'h0);

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_pre_nxt   = r_pre;
    w_tick_nxt  = 1'b0;
    if (w_load) begin
      w_count_nxt = sw_d;
      w_state_nxt = StIdle;
      w_pre_nxt   = '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (!w_stop && w_start) begin
            w_state_nxt = StRun;
            w_pre_nxt   = '0;
          end
        end
        StRun: begin
          if (w_roll) begin
            w_pre_nxt = '0;
            // Non-wrapping terminal step overrides a simultaneous stop.
            if (w_term && !wrap_en) begin
              w_state_nxt = StDone;
            end else begin
              w_count_nxt = up ? r_count + 4'd1 : r_count - 4'd1;
              w_tick_nxt  = 1'b1;
              if (w_stop) w_state_nxt = StPause;
            end
          end else begin
            w_pre_nxt = r_pre + PreW'(1);
            if (w_stop) w_state_nxt = StPause;
          end
        end
        StPause: begin
          if (w_stop) begin
            w_state_nxt = StIdle;
            w_pre_nxt   = '0;
          end else if (w_start) begin
            w_state_nxt = StRun;
          end
        end
        StDone: begin
          if (w_stop) w_state_nxt = StIdle;
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_count <= 4'h0;
      r_pre   <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_pre   <= w_pre_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  assign count = r_count;
  assign state = r_state;
  assign tick  = r_tick;
  assign done  = (r_state == StDone);
  assign busy  = (r_state == StRun) || (r_state == StPause);

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: directed table, hand sequences and a random run
// checked every cycle against a cycle-level behavioural model.
module tb_counter_sequencer;

  localparam int PRESCALE = 4;
  localparam int DC       = 4;
`ifdef CNT_SEQ_DEBOUNCE_EN
  localparam int LAT = 2 + DC;
  localparam int GAP = DC + 3;
`else
  localparam int LAT = 2;
  localparam int GAP = 2;
`endif

  logic       clk;
  logic       rst_n;
  logic       key_start_n;
  logic       key_stop_n;
  logic       key_load_n;
  logic [3:0] sw_d;
  logic       up;
  logic       wrap_en;
  logic [3:0] count;
  logic [1:0] state;
  logic       tick;
  logic       done;
  logic       busy;

  counter_sequencer #(
    .PRESCALE       (PRESCALE),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_start_n(key_start_n),
    .key_stop_n (key_stop_n),
    .key_load_n (key_load_n),
    .sw_d       (sw_d),
    .up         (up),
    .wrap_en    (wrap_en),
    .count      (count),
    .state      (state),
    .tick       (tick),
    .done       (done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: key sample history per key, state as spec codes, RUN cycles since tick.
  logic [15:0] m_hist [3];
  logic [2:0]  m_filt;
  int          m_state;
  int          m_count;
  int          m_run;
  logic        m_tick;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_hist[i] = 16'hFFFF;
    m_filt  = 3'b111;
    m_state = 0;
    m_count = 0;
    m_run   = 0;
    m_tick  = 1'b0;
  endtask

  task automatic model_update();
    logic [2:0] keys;
    logic [2:0] cmd;
    logic       term;
    if (!rst_n) begin
      model_reset();
      return;
    end
    keys = {key_load_n, key_stop_n, key_start_n};
    for (int i = 0; i < 3; i++) begin
      m_hist[i] = {m_hist[i][14:0], keys[i]};
`ifdef CNT_SEQ_DEBOUNCE_EN
      begin
        logic fl;
        fl = 1'b1;
        for (int j = 3; j <= DC + 2; j++) if (m_hist[i][j] == m_filt[i]) fl = 1'b0;
        cmd[i] = fl & m_filt[i];
        if (fl) m_filt[i] = ~m_filt[i];
      end
`else
      cmd[i] = m_hist[i][3] & ~m_hist[i][2];
`endif
    end
    m_tick = 1'b0;
    if (cmd[2]) begin
      m_count = int'(sw_d);
      m_state = 0;
      m_run   = 0;
    end else if (m_state == 0) begin
      if (!cmd[1] && cmd[0]) begin
        m_state = 1;
        m_run   = 0;
      end
    end else if (m_state == 1) begin
      m_run++;
      if (m_run == PRESCALE) begin
        m_run = 0;
        term  = up ? (m_count == 15) : (m_count == 0);
        if (term && !wrap_en) begin
          m_state = 3;
        end else begin
          m_count = up ? (m_count + 1) % 16 : (m_count + 15) % 16;
          m_tick  = 1'b1;
        end
      end
      if (m_state == 1 && cmd[1]) m_state = 2;
    end else if (m_state == 2) begin
      if (cmd[1]) begin
        m_state = 0;
        m_run   = 0;
      end else if (cmd[0]) begin
        m_state = 1;
      end
    end else begin
      if (cmd[1]) m_state = 0;
    end
  endtask

  task automatic compare();
    logic [8:0] exp;
    exp = {m_count[3:0], m_state[1:0], m_tick, (m_state == 3), (m_state == 1 || m_state == 2)};
    chk("model", {7'd0, count, state, tick, done, busy}, {7'd0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic settle();
    repeat (GAP) step();
  endtask

  // mask bits: [0] start, [1] stop, [2] load; returns one cycle after the command's edge
  task automatic press(input logic [2:0] mask);
    key_start_n = ~mask[0];
    key_stop_n  = ~mask[1];
    key_load_n  = ~mask[2];
    repeat (LAT + 1) step();
    key_start_n = 1'b1;
    key_stop_n  = 1'b1;
    key_load_n  = 1'b1;
  endtask

  typedef struct {
    logic [2:0] keys;
    logic [3:0] sw;
    logic       up;
    logic       wrap;
    int         waitc;
    logic [3:0] cnt;
    logic [1:0] st;
    logic       tk;
  } vec_t;

  vec_t tbl [14];
  int   hold [3];

  initial begin
    rst_n       = 1'b1;
    key_start_n = 1'b1;
    key_stop_n  = 1'b1;
    key_load_n  = 1'b1;
    sw_d        = 4'd0;
    up          = 1'b1;
    wrap_en     = 1'b0;
    model_reset();

    tbl[0]  = '{3'b100, 4'd9,  1'b1, 1'b0, 0, 4'd9,  2'b00, 1'b0};
    tbl[1]  = '{3'b100, 4'd13, 1'b1, 1'b0, 0, 4'd13, 2'b00, 1'b0};
    tbl[2]  = '{3'b001, 4'd13, 1'b1, 1'b0, 0, 4'd13, 2'b01, 1'b0};
    tbl[3]  = '{3'b000, 4'd13, 1'b1, 1'b0, 4, 4'd14, 2'b01, 1'b1};
    tbl[4]  = '{3'b000, 4'd13, 1'b1, 1'b0, 4, 4'd15, 2'b01, 1'b1};
    tbl[5]  = '{3'b000, 4'd13, 1'b1, 1'b0, 4, 4'd15, 2'b11, 1'b0};
    tbl[6]  = '{3'b001, 4'd13, 1'b1, 1'b0, 0, 4'd15, 2'b11, 1'b0};
    tbl[7]  = '{3'b010, 4'd13, 1'b1, 1'b0, 0, 4'd15, 2'b00, 1'b0};
    tbl[8]  = '{3'b100, 4'd1,  1'b0, 1'b1, 0, 4'd1,  2'b00, 1'b0};
    tbl[9]  = '{3'b001, 4'd1,  1'b0, 1'b1, 0, 4'd1,  2'b01, 1'b0};
    tbl[10] = '{3'b000, 4'd1,  1'b0, 1'b1, 4, 4'd0,  2'b01, 1'b1};
    tbl[11] = '{3'b000, 4'd1,  1'b0, 1'b1, 4, 4'd15, 2'b01, 1'b1};
    tbl[12] = '{3'b000, 4'd1,  1'b0, 1'b1, 4, 4'd14, 2'b01, 1'b1};
    tbl[13] = '{3'b000, 4'd1,  1'b0, 1'b1, 2, 4'd14, 2'b01, 1'b0};

    // Reset state
    #1 rst_n = 1'b0;
    model_reset();
    #1 chk("reset", {8'd0, count, state, tick, done, busy}, 16'd0);
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Table: load, up without wrap to DONE, down with wrap
    for (int i = 0; i < 14; i++) begin
      sw_d    = tbl[i].sw;
      up      = tbl[i].up;
      wrap_en = tbl[i].wrap;
      if (tbl[i].keys != 3'b000) begin
        settle();
        press(tbl[i].keys);
      end else begin
        repeat (tbl[i].waitc) step();
      end
      chk($sformatf("vec%0d", i), {9'd0, count, state, tick}, {9'd0, tbl[i].cnt, tbl[i].st, tbl[i].tk});
      if (tbl[i].st == 2'b11) chk($sformatf("vec%0d_done", i), {15'd0, done}, 16'd1);
      else chk($sformatf("vec%0d_done", i), {15'd0, done}, 16'd0);
    end

    // Pause and resume: PAUSE entered two RUN cycles after the second tick
    sw_d    = 4'd0;
    up      = 1'b1;
    wrap_en = 1'b1;
    settle();
    press(3'b100);
    press(3'b001);
    repeat (9 - LAT) step();
    press(3'b010);
    chk("pause_state", {14'd0, state}, 16'd2);
    chk("pause_count", {12'd0, count}, 16'd2);
    chk("pause_busy", {15'd0, busy}, 16'd1);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("pause_frozen", {9'd0, count, state, tick}, {9'd0, 4'd2, 2'b10, 1'b0});
    end
    press(3'b001);
    chk("resume_s1", {9'd0, count, state, tick}, {9'd0, 4'd2, 2'b01, 1'b0});
    step();
    chk("resume_s2", {9'd0, count, state, tick}, {9'd0, 4'd2, 2'b01, 1'b0});
    step();
    chk("resume_tick", {9'd0, count, state, tick}, {9'd0, 4'd3, 2'b01, 1'b1});
    press(3'b010);
    chk("pause2", {14'd0, state}, 16'd2);
    settle();
    press(3'b010);
    chk("pause_stop_idle", {14'd0, state}, 16'd0);
    chk("idle_busy", {15'd0, busy}, 16'd0);

    // All three keys at once in RUN: load wins
    settle();
    press(3'b001);
    settle();
    sw_d = 4'd5;
    press(3'b111);
    chk("prio_load", {10'd0, count, state}, {10'd0, 4'd5, 2'b00});

    // Asynchronous reset between clock edges while running
    settle();
    press(3'b001);
    repeat (6) step();
    chk("run_before_rst", {14'd0, state}, 16'd1);
    #3 rst_n = 1'b0;
    model_reset();
    #1 chk("async_rst", {8'd0, count, state, tick, done, busy}, 16'd0);
    repeat (2) step();
    rst_n = 1'b1;
    settle();

    // Short glitch on start from IDLE
    key_start_n = 1'b0;
    repeat (2) step();
    key_start_n = 1'b1;
    repeat (LAT + DC + 2) step();
`ifdef CNT_SEQ_DEBOUNCE_EN
    chk("glitch_ignored", {14'd0, state}, 16'd0);
    settle();
    key_start_n = 1'b0;
    repeat (6) step();
    chk("press6_e5", {14'd0, state}, 16'd0);
    key_start_n = 1'b1;
    step();
    chk("press6_e6", {14'd0, state}, 16'd1);
`else
    chk("glitch_starts", {14'd0, state}, 16'd1);
`endif

    // Random stimulus against the model
    for (int i = 0; i < 3; i++) hold[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      logic [2:0] kn;
      kn = 3'b111;
      for (int i = 0; i < 3; i++) begin
        if (hold[i] > 0) begin
          hold[i]--;
          kn[i] = 1'b0;
        end else if ($urandom_range(0, (i == 2) ? 60 : 14) == 0) begin
          hold[i] = int'($urandom_range(1, 9));
          kn[i]   = 1'b0;
        end
      end
      key_start_n = kn[0];
      key_stop_n  = kn[1];
      key_load_n  = kn[2];
      sw_d        = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) up = ~up;
      if ($urandom_range(0, 19) == 0) wrap_en = ~wrap_en;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
